ula_requisitante: RTL and testbench

// Initiator side of the ULA processar/concluido handshake. Accepts one operation
// (op, two operands) from upstream via valid/ready, drives the ULA operand/op

---
 rtl/ula_requisitante_if.sv | 41 ++++
 rtl/ula_requisitante.sv | 174 +++++++++++++++++
 tb/tb_ula_requisitante.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_requisitante_if.sv
// ---------------------------------------------------------------------------
// ula_requisitante_if
// Bundles the three buses around the ULA requester:
//   - upstream request : req_valido/req_pronto handshake with req_op, req_a, req_b
//   - ULA side         : ETp1, ETp2, op, processar out; concluido, Data back
//   - upstream result  : res_valido/res_pronto handshake with res_dado, res_erro
// Modport master is the requester itself; modport slave is everything around it
// (the upstream producer/consumer and the ULA).
// W must equal the requester's TAMANHO_DA_PALAVRA.
// ---------------------------------------------------------------------------
interface ula_requisitante_if #(
    parameter int W = 16
) ();
    logic          req_valido;
    logic          req_pronto;
    logic [3:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;

    logic [W-1:0]  ETp1;
    logic [W-1:0]  ETp2;
    logic [3:0]    op;
    logic          processar;
    logic          concluido;
    logic [W-1:0]  Data;

    logic          res_valido;
    logic          res_pronto;
    logic [W-1:0]  res_dado;
    logic [1:0]    res_erro;

    modport master (
        input  req_valido, req_op, req_a, req_b, concluido, Data, res_pronto,
        output req_pronto, ETp1, ETp2, op, processar, res_valido, res_dado, res_erro
    );

    modport slave (
        output req_valido, req_op, req_a, req_b, concluido, Data, res_pronto,
        input  req_pronto, ETp1, ETp2, op, processar, res_valido, res_dado, res_erro
    );
endinterface

// File: rtl/ula_requisitante.sv
// ---------------------------------------------------------------------------
// ula_requisitante
// Initiator side of the ULA processar/concluido handshake. Takes one operation
// from upstream, drives it to the ULA, waits for concluido, captures Data and
// hands the result back upstream. Illegal opcodes are rejected without touching
// the ULA, and a hung ULA is caught by a timeout in ENVIA and in LIBERA.
// Ports:
//   clk            clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   bus            ula_requisitante_if.master (request, ULA and result buses)
//   ops_concluidas number of ok results delivered, wraps 255 -> 0
// res_erro codes: 0 ok, 1 illegal opcode, 2 timeout. All outputs registered.
// ---------------------------------------------------------------------------
module ula_requisitante #(
    parameter int TAMANHO_DA_PALAVRA = 16,
    parameter int LIMITE_ESPERA      = 32,
    parameter int OP_MAX             = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    ula_requisitante_if.master   bus,
    output logic [7:0]           ops_concluidas
);
    localparam int W  = TAMANHO_DA_PALAVRA;
    localparam int TW = (LIMITE_ESPERA > 2) ? $clog2(LIMITE_ESPERA) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(LIMITE_ESPERA - 1);
    localparam logic [3:0]    OP_LIMITE = 4'(OP_MAX);

    typedef enum logic [1:0] {
        OCIOSO,
        ENVIA,
        LIBERA,
        ENTREGA
    } estado_t;

    estado_t        r_estado,    w_estadoProx;
    logic           r_reqPronto, w_reqPronto;
    logic [3:0]     r_op,        w_op;
    logic [W-1:0]   r_etp1,      w_etp1;
    logic [W-1:0]   r_etp2,      w_etp2;
    logic           r_processar, w_processar;
    logic           r_resValido, w_resValido;
    logic [W-1:0]   r_resDado,   w_resDado;
    logic [1:0]     r_resErro,   w_resErro;
    logic [TW-1:0]  r_timer,     w_timer;
    logic [7:0]     r_ops,       w_ops;

    // State and every output register; reset clears all of them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_reqPronto <= 1'b0;
            r_op        <= '0;
            r_etp1      <= '0;
            r_etp2      <= '0;
            r_processar <= 1'b0;
            r_resValido <= 1'b0;
            r_resDado   <= '0;
            r_resErro   <= '0;
            r_timer     <= '0;
            r_ops       <= '0;
        end else begin
            r_estado    <= w_estadoProx;
            r_reqPronto <= w_reqPronto;
            r_op        <= w_op;
            r_etp1      <= w_etp1;
            r_etp2      <= w_etp2;
            r_processar <= w_processar;
            r_resValido <= w_resValido;
            r_resDado   <= w_resDado;
            r_resErro   <= w_resErro;
            r_timer     <= w_timer;
            r_ops       <= w_ops;
        end
    end

    // Next-state and next-output logic. req_pronto is only ever raised for a
    // cycle spent in OCIOSO, and is withheld while the ULA still shows concluido
    // from a previous (possibly timed-out) operation so that stale flag is
    // absorbed here instead of being mistaken for the new result.
    // The single timer is reused: cleared on acceptance for ENVIA and cleared
    // again on entry to LIBERA.
    always_comb begin
        w_estadoProx = r_estado;
        w_reqPronto  = 1'b0;
        w_op         = r_op;
        w_etp1       = r_etp1;
        w_etp2       = r_etp2;
        w_processar  = r_processar;
        w_resValido  = r_resValido;
        w_resDado    = r_resDado;
        w_resErro    = r_resErro;
        w_timer      = r_timer;
        w_ops        = r_ops;

        case (r_estado)
            OCIOSO: begin
                w_reqPronto = ~bus.concluido;
                if (bus.req_valido && r_reqPronto) begin
                    w_reqPronto = 1'b0;
                    w_op        = bus.req_op;
                    w_etp1      = bus.req_a;
                    w_etp2      = bus.req_b;
                    w_timer     = '0;
                    if (bus.req_op > OP_LIMITE) begin
                        w_resDado    = '0;
                        w_resErro    = 2'd1;
                        w_resValido  = 1'b1;
                        w_estadoProx = ENTREGA;
                    end else begin
                        w_processar  = 1'b1;
                        w_estadoProx = ENVIA;
                    end
                end
            end

            ENVIA: begin
                w_timer = r_timer + TW'(1);
                if (bus.concluido) begin
                    w_resDado    = bus.Data;
                    w_resErro    = 2'd0;
                    w_processar  = 1'b0;
                    w_timer      = '0;
                    w_estadoProx = LIBERA;
                end else if (r_timer == TIMER_MAX) begin
                    w_resDado    = '0;
                    w_resErro    = 2'd2;
                    w_processar  = 1'b0;
                    w_timer      = '0;
                    w_estadoProx = LIBERA;
                end
            end

            LIBERA: begin
                if (!bus.concluido) begin
                    w_resValido  = 1'b1;
                    w_estadoProx = ENTREGA;
                end else if (r_timer == TIMER_MAX) begin
                    w_resDado    = '0;
                    w_resErro    = 2'd2;
                    w_resValido  = 1'b1;
                    w_estadoProx = ENTREGA;
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end

            ENTREGA: begin
                if (bus.res_pronto) begin
                    w_resValido  = 1'b0;
                    w_reqPronto  = ~bus.concluido;
                    w_estadoProx = OCIOSO;
                    if (r_resErro == 2'd0) begin
                        w_ops = r_ops + 8'd1;
                    end
                end
            end

            default: begin
                w_estadoProx = OCIOSO;
            end
        endcase
    end

    assign bus.req_pronto = r_reqPronto;
    assign bus.op         = r_op;
    assign bus.ETp1       = r_etp1;
    assign bus.ETp2       = r_etp2;
    assign bus.processar  = r_processar;
    assign bus.res_valido = r_resValido;
    assign bus.res_dado   = r_resDado;
    assign bus.res_erro   = r_resErro;
    assign ops_concluidas = r_ops;
endmodule

// File: tb/tb_ula_requisitante.sv
// ---------------------------------------------------------------------------
// tb_ula_requisitante
// Drives ula_requisitante with directed requests against a behavioural ULA
// that can also be made to hang. Expected results are queued when a request
// is issued and a separate monitor pops and compares them whenever a result
// is handed over upstream.
// ---------------------------------------------------------------------------
module tb_ula_requisitante;
    typedef struct {
        logic [15:0] dado;
        logic [1:0]  erro;
    } esperado_t;

    logic        clk;
    logic        reset;
    logic [7:0]  ops;

    ula_requisitante_if #(.W(16)) bus ();

    ula_requisitante #(
        .TAMANHO_DA_PALAVRA (16),
        .LIMITE_ESPERA      (32),
        .OP_MAX             (9)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .ops_concluidas (ops)
    );

    esperado_t sbQ[$];
    int total = 0;
    int bad = 0;
    int nResults = 0;
    int procCycles = 0;
    logic ulaTravada = 1'b0;

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: answers one cycle after seeing processar, holds
    // concluido until processar drops, then returns to its wait state.
    // When ulaTravada is set it never answers.
    function automatic logic [15:0] calcula(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (o)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a * b;
            4'd3:    r = (b != 16'd0) ? a / b : 16'd0;
            4'd9:    r = ~a;
            default: r = 16'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.concluido <= 1'b0;
            bus.Data      <= 16'd0;
        end else if (ulaTravada) begin
            bus.concluido <= 1'b0;
        end else if (!bus.concluido) begin
            if (bus.processar) begin
                bus.concluido <= 1'b1;
                bus.Data      <= calcula(bus.op, bus.ETp1, bus.ETp2);
            end
        end else if (!bus.processar) begin
            bus.concluido <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: one comparison per upstream handover.
    always @(negedge clk) begin
        esperado_t e;
        if (reset && bus.res_valido && bus.res_pronto) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedResult", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("resDado", 32'(bus.res_dado), 32'(e.dado));
                checkOutput("resErro", 32'(bus.res_erro), 32'(e.erro));
            end
            nResults++;
        end
    end

    // Counts cycles with processar high, for pulse-length checks.
    always @(negedge clk) begin
        if (bus.processar) procCycles++;
    end

    task automatic applyStimulus(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expDado, input logic [1:0] expErro);
        esperado_t e;
        int n = 0;
        e.dado = expDado;
        e.erro = expErro;
        sbQ.push_back(e);
        @(negedge clk);
        bus.req_valido = 1'b1;
        bus.req_op     = o;
        bus.req_a      = a;
        bus.req_b      = b;
        while (!bus.req_pronto && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("reqAcceptTimeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.req_valido = 1'b0;
    endtask

    task automatic waitResult(input int target);
        int n = 0;
        while (nResults < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (nResults < target) checkOutput("resultTimeout", 32'(nResults), 32'(target));
        @(negedge clk);
    endtask

    initial begin
        int unstable;
        int n;
        int expCount;
        bus.req_valido = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_a      = 16'd0;
        bus.req_b      = 16'd0;
        bus.res_pronto = 1'b1;
        reset = 1'b1;
        #3 reset = 1'b0;
        #4;
        checkOutput("rstProcessar", 32'(bus.processar), 32'd0);
        checkOutput("rstResValido", 32'(bus.res_valido), 32'd0);
        checkOutput("rstReqPronto", 32'(bus.req_pronto), 32'd0);
        checkOutput("rstOps", 32'(ops), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", 32'(bus.req_pronto), 32'd1);

        // Basic arithmetic through the handshake.
        applyStimulus(4'd0, 16'd7, 16'd5, 16'd12, 2'd0);
        waitResult(1);
        checkOutput("opsAfterSoma", 32'(ops), 32'd1);
        applyStimulus(4'd2, 16'd300, 16'd300, 16'h5F90, 2'd0);
        waitResult(2);
        applyStimulus(4'd3, 16'd100, 16'd7, 16'd14, 2'd0);
        waitResult(3);
        applyStimulus(4'd9, 16'h00FF, 16'd0, 16'hFF00, 2'd0);
        waitResult(4);
        checkOutput("opsAfterFour", 32'(ops), 32'd4);

        // Illegal opcodes never reach the ULA.
        procCycles = 0;
        applyStimulus(4'd12, 16'd1, 16'd2, 16'd0, 2'd1);
        waitResult(5);
        applyStimulus(4'd10, 16'd1, 16'd2, 16'd0, 2'd1);
        waitResult(6);
        checkOutput("illegalNoProcessar", 32'(procCycles), 32'd0);
        checkOutput("opsAfterIllegal", 32'(ops), 32'd4);

        // Hung ULA: processar held exactly 32 cycles, then timeout result.
        ulaTravada = 1'b1;
        procCycles = 0;
        applyStimulus(4'd0, 16'd1, 16'd1, 16'd0, 2'd2);
        waitResult(7);
        checkOutput("timeoutProcCycles", 32'(procCycles), 32'd32);
        checkOutput("opsAfterTimeout", 32'(ops), 32'd4);
        ulaTravada = 1'b0;

        // Upstream stalls: result must stay put and no new request accepted.
        bus.res_pronto = 1'b0;
        applyStimulus(4'd0, 16'd2, 16'd3, 16'd5, 2'd0);
        n = 0;
        while (!bus.res_valido && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stallValid", 32'(bus.res_valido), 32'd1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.res_valido || bus.res_dado !== 16'd5 || bus.req_pronto) unstable++;
        end
        checkOutput("stallStable", 32'(unstable), 32'd0);
        bus.res_pronto = 1'b1;
        waitResult(8);
        checkOutput("opsAfterStall", 32'(ops), 32'd5);

        // Reset in the middle of ENVIA.
        ulaTravada = 1'b1;
        applyStimulus(4'd0, 16'd4, 16'd4, 16'd8, 2'd0);
        n = 0;
        while (!bus.processar && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("envProcessar", 32'(bus.processar), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstProcessar", 32'(bus.processar), 32'd0);
        checkOutput("midRstResValido", 32'(bus.res_valido), 32'd0);
        checkOutput("midRstOps", 32'(ops), 32'd0);
        sbQ.delete();
        ulaTravada = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstIdleReady", 32'(bus.req_pronto), 32'd1);
        checkOutput("midRstIdleProc", 32'(bus.processar), 32'd0);

        // 256 ok operations wrap the counter back to zero.
        expCount = nResults;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'd0, 16'(i), 16'(2 * i + 1), 16'(3 * i + 1), 2'd0);
            expCount++;
            waitResult(expCount);
            if (i == 254) checkOutput("ops255", 32'(ops), 32'd255);
        end
        checkOutput("opsWrap", 32'(ops), 32'd0);
        checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
